// File: rtl/sa_2d.sv
// sa_2d: output-stationary HPE x VPE systolic array of unsigned multiply-accumulate PEs.
//
// Row operands enter at the left edge and shift one column right per clock; column operands
// enter at the top edge and shift one row down per clock. Every PE accumulates the product of
// the operands passing through it into a private 2*WIDTH-bit accumulator that wraps on overflow.
// The caller is responsible for skewing lanes when a matrix product is wanted.
//
// Parameters:
//   HPE   - number of rows (A lanes)
//   VPE   - number of columns (B lanes)
//   WIDTH - operand width; accumulators are 2*WIDTH bits
// Ports:
//   AA  - HPE packed row operands, lane r at AA[r*WIDTH +: WIDTH]
//   BB  - VPE packed column operands, lane c at BB[c*WIDTH +: WIDTH]
//   CLK - clock, rising edge active
//   RST - asynchronous active-low reset, clears all state
//   Y   - all accumulators; PE(0,0) in the MSBs, PE(HPE-1,VPE-1) in the LSBs
module sa_2d #(
  parameter int unsigned HPE   = 4,
  parameter int unsigned VPE   = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH*HPE-1:0]       AA,
  input  logic [WIDTH*VPE-1:0]       BB,
  input  logic                       CLK,
  input  logic                       RST,
  output logic [2*WIDTH*HPE*VPE-1:0] Y
);

  localparam int unsigned N    = HPE * VPE;
  localparam int unsigned AccW = 2 * WIDTH;

  // Operand seen by each PE this cycle: an edge lane or the neighbour's forwarded register.
  logic [WIDTH-1:0] w_a_in [HPE][VPE];
  logic [WIDTH-1:0] w_b_in [HPE][VPE];

  for (genvar r = 0; r < HPE; r++) begin : g_row
    for (genvar c = 0; c < VPE; c++) begin : g_col
      localparam int unsigned K = r * VPE + c;

      logic [AccW-1:0] r_acc;
      logic [AccW-1:0] w_prod;

      // Zero-extend both operands so the product is formed at full accumulator width.
      assign w_prod = {{WIDTH{1'b0}}, w_a_in[r][c]} * {{WIDTH{1'b0}}, w_b_in[r][c]};

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          r_acc <= '0;
        end else begin
          r_acc <= r_acc + w_prod;
        end
      end

      assign Y[(N-K-1)*AccW +: AccW] = r_acc;

      if (c == 0) begin : g_a_edge
        assign w_a_in[r][0] = AA[r*WIDTH +: WIDTH];
      end

      if (r == 0) begin : g_b_edge
        assign w_b_in[0][c] = BB[c*WIDTH +: WIDTH];
      end

      // The last column's a_reg and last row's b_reg feed nothing observable, so they are
      // only built where a neighbour consumes them.
      if (c < VPE - 1) begin : g_a_fwd
        logic [WIDTH-1:0] r_a;
        always_ff @(posedge CLK or negedge RST) begin
          if (!RST) begin
            r_a <= '0;
          end else begin
            r_a <= w_a_in[r][c];
          end
        end
        assign w_a_in[r][c+1] = r_a;
      end

      if (r < HPE - 1) begin : g_b_fwd
        logic [WIDTH-1:0] r_b;
        always_ff @(posedge CLK or negedge RST) begin
          if (!RST) begin
            r_b <= '0;
          end else begin
            r_b <= w_b_in[r][c];
          end
        end
        assign w_b_in[r+1][c] = r_b;
      end
    end
  end

endmodule

// File: tb/tb_sa_2d.sv
// tb_sa_2d: directed self-checking bench for the 4x4, 8-bit sa_2d array.
module tb_sa_2d;

  localparam int H = 4;
  localparam int V = 4;
  localparam int W = 8;

  logic [W*H-1:0]     AA;
  logic [W*V-1:0]     BB;
  logic               CLK;
  logic               RST;
  logic [2*W*H*V-1:0] Y;

  int n_cmp;
  int n_mis;

  sa_2d #(
    .HPE  (H),
    .VPE  (V),
    .WIDTH(W)
  ) u_dut (
    .AA (AA),
    .BB (BB),
    .CLK(CLK),
    .RST(RST),
    .Y  (Y)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] pe(input int r, input int c);
    int k;
    k = r * V + c;
    return Y[(H*V-k-1)*16 +: 16];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic set_all(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < H; i++) AA[i*W +: W] = a;
    for (int i = 0; i < V; i++) BB[i*W +: W] = b;
  endtask

  // Called 1 ns after an edge; pulses reset well clear of any edge.
  task automatic do_reset();
    AA  = '0;
    BB  = '0;
    RST = 1'b0;
    #2;
    RST = 1'b1;
    #1;
  endtask

  int nz;
  int exp_u;
  int d;

  initial begin
    n_cmp = 0;
    n_mis = 0;

    // Reset holds everything at zero regardless of operands.
    RST = 1'b0;
    set_all(8'd7, 8'd9);
    tick(3);
    check("rst_hold_y_zero", {31'b0, |Y}, 32'd0);
    AA = '0;
    BB = '0;
    RST = 1'b1;
    tick(2);
    check("rst_release_y_zero", {31'b0, |Y}, 32'd0);

    // Single PE: only PE(0,0) sees both operands together.
    do_reset();
    AA[0 +: W] = 8'd3;
    BB[0 +: W] = 8'd5;
    tick(1);
    check("single_pe00_latency", pe(0, 0), 32'd15);
    AA = '0;
    BB = '0;
    tick(8);
    check("single_pe00", pe(0, 0), 32'd15);
    nz = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < V; c++)
        if (!(r == 0 && c == 0) && pe(r, c) != 0) nz++;
    check("single_others_zero", nz, 32'd0);

    // Uniform stream: PE(r,c) sees 4-|r-c| overlapping operand pairs of 2*3.
    do_reset();
    set_all(8'd2, 8'd3);
    tick(4);
    set_all(8'd0, 8'd0);
    tick(8);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < V; c++) begin
        d = (r > c) ? r - c : c - r;
        exp_u = 6 * (4 - d);
        check($sformatf("uniform_pe%0d%0d", r, c), pe(r, c), exp_u);
      end
    end

    // Skewed stimulus: lane n = m+1-n, then held at 4,3,2,1.
    do_reset();
    begin
      int exp_s [6] = '{1, 5, 14, 30, 46, 62};
      for (int m = 0; m < 6; m++) begin
        for (int n = 0; n < 4; n++) begin
          int v;
          v = (m < 4) ? m + 1 - n : 4 - n;
          if (v < 0) v = 0;
          AA[n*W +: W] = v[7:0];
          BB[n*W +: W] = v[7:0];
        end
        tick(1);
        check($sformatf("skew_pe00_edge%0d", m), pe(0, 0), exp_s[m]);
      end
    end

    // Wraparound modulo 2^16.
    do_reset();
    AA[0 +: W] = 8'd255;
    BB[0 +: W] = 8'd255;
    tick(1);
    check("wrap_edge0", pe(0, 0), 32'd65025);
    tick(1);
    check("wrap_edge1", pe(0, 0), 32'd64514);

    // Mid-operation reset clears immediately and restarts from zero.
    do_reset();
    set_all(8'd2, 8'd3);
    tick(2);
    check("mid_pre_pe00", pe(0, 0), 32'd12);
    check("mid_pre_pe01", pe(0, 1), 32'd6);
    RST = 1'b0;
    #1;
    check("mid_rst_y_zero", {31'b0, |Y}, 32'd0);
    #2;
    RST = 1'b1;
    tick(1);
    check("mid_restart_pe00", pe(0, 0), 32'd6);
    check("mid_restart_pe01", pe(0, 1), 32'd0);
    tick(1);
    check("mid_restart2_pe00", pe(0, 0), 32'd12);
    check("mid_restart2_pe01", pe(0, 1), 32'd6);
    check("mid_restart2_pe11", pe(1, 1), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sa_2d.md
# sa_2d

Output-stationary 2D systolic array (`sa_2D`) of HPE×VPE multiply-accumulate processing elements (PEs) for unsigned 8-bit operands. Each PE keeps a 16-bit accumulator.
- Row operands enter on the left edge and shift right one PE per clock.
- Column operands enter on the top edge and shift down one PE per clock.
- All accumulators are exposed in parallel on one flat output bus.

It sits as the compute core under a controller, which is responsible for skewing and streaming operands.

## Interface
Parameters:
- HPE, default 4: number of rows, equal to the number of A lanes (first positional parameter).
- VPE, default 4: number of columns, equal to the number of B lanes (second positional parameter).
- WIDTH, default 8: operand width. The accumulator is 2*WIDTH wide.

Ports (positional order AA, BB, CLK, RST, Y):
- CLK  in  1: single clock; all state updates on its rising edge.
- RST  in  1: asynchronous, active-low reset.
- AA  in  WIDTH*HPE: row operands. Lane r = AA[(r+1)*WIDTH-1 : r*WIDTH] feeds row r.
- BB  in  WIDTH*VPE: column operands. Lane c = BB[(c+1)*WIDTH-1 : c*WIDTH] feeds column c.
- Y  out  2*WIDTH*HPE*VPE: all accumulators.
  - N = HPE*VPE and k = r*VPE + c.
  - PE(r,c) drives Y[(N-k)*2*WIDTH-1 : (N-k-1)*2*WIDTH].
  - PE(0,0) occupies the MSBs; PE(HPE-1,VPE-1) occupies the LSBs.

## Operation
- PE(r,c) has three registers:
  - a_reg (WIDTH bits), forwarded to PE(r,c+1);
  - b_reg (WIDTH bits), forwarded to PE(r+1,c);
  - acc (2*WIDTH bits), driven directly onto its Y slice.
- PE inputs:
  - a_in is AA lane r when c=0, otherwise a_reg of PE(r,c-1).
  - b_in is BB lane c when r=0, otherwise b_reg of PE(r-1,c).
- Each rising edge with RST=1, every PE updates simultaneously:
  - acc <= acc + a_in*b_in;
  - a_reg <= a_in;
  - b_reg <= b_in.
- Arithmetic:
  - The product is unsigned, WIDTH×WIDTH giving 2*WIDTH bits.
  - The sum wraps modulo 2^(2*WIDTH), with no saturation and no overflow flag.
- There is no internal input skew. The caller applies the skew (lane n delayed n cycles) when a matrix product is wanted.
- There is no clear or enable input. Accumulation continues every cycle and is cleared only by reset. Zero operands hold acc unchanged.
- a_reg and b_reg of edge PEs are not output. Data shifted out of the last column or row is discarded.

## Timing
- RST=0 asynchronously forces every acc, a_reg and b_reg to 0, so Y = 0 immediately. Values hold at 0 while RST is low.
- Asserting reset mid-accumulation discards all state. On the first edge after RST returns high, the array resumes from all zeros with no partial results retained.
- Latency:
  - An AA/BB value stable before edge t is reflected in acc of PE(0,0) right after edge t.
  - A-lane data reaches column c c cycles later.
  - B-lane data reaches row r r cycles later.
  - The contribution of PE(r,c) appears after edge t+max(r,c) when operands are co-timed.
- Y changes only on rising CLK edges or asynchronous reset. There are no combinational paths from AA/BB to Y.
- Throughput: one new operand pair per lane per cycle.

## Test plan
- Reset: drive RST=0 with nonzero AA/BB, toggle CLK → Y stays all-zero. Release RST with AA=BB=0 → Y stays 0.
- Single PE: after reset, apply AA lane0=3, BB lane0=5, all other lanes 0, for one edge, then all zeros for 8 edges.
  - PE(0,0) = 15.
  - All other PEs = 0, because the shifted 3 meets B=0 and vice versa.
- Uniform stream (HPE=VPE=4): apply all A lanes=2 and all B lanes=3 for K=4 edges, then zeros for 8 edges → PE(r,c) = 6*(4-|r-c|).
  - Diagonal PEs = 24.
  - |r-c|=1 → 18; |r-c|=2 → 12; |r-c|=3 → 6.
- Skewed matrix stimulus:
  - Step m=0..3 sets lane n = m+1-n when positive, else 0, for both AA and BB, one value per 10 ns clock.
  - The values are then held at 4,3,2,1.
  - Check PE(0,0) after each edge: 1, 5, 14, 30, then increments of 16 per edge.
- Wraparound: hold A lane0=B lane0=255 (others 0) for 2 edges → PE(0,0) = 65025, then 64514 (130050 mod 65536).
- Mid-operation reset: during the uniform stream, pulse RST low between edges → Y is 0 immediately. Accumulation restarts from 0 on the next edge.
